sb_param_shadow_cfg: RTL and testbench
======================================

// Module: sb_param_shadow_cfg
// PURPOSE
//  Parametrised successor of the fixed left-edge switch block (x=0 column). It routes CHAN_WIDTH-wide X/Y channels plus
//  grid pins through configurable muxes. Configuration is loaded serially through a ccff chain into a shift register,
//  then committed atomically to an active register, so routing never glitches while the chain is loading.
//  Bit-count checking flags short or over-length loads.
// PARAMETERS
//  CHAN_WIDTH    12  tracks per channel direction; even, >=4
//  NUM_OPINS     8   right-bottom grid output pins
//  WIDE_MUXES    2   right tracks 0..WIDE_MUXES-1 use wide muxes; 1..CHAN_WIDTH-2
//  BOTTOM_MUXES  3   bottom tracks 0..BOTTOM_MUXES-1 are muxed; 1..CHAN_WIDTH-2
//  derived: SW = clog2(NUM_OPINS+2)
//           CFG_BITS = WIDE_MUXES*SW + (CHAN_WIDTH-1-WIDE_MUXES) + BOTTOM_MUXES  (default 20)
// PORTS
//  prog_clk           in   1             configuration/register clock
//  prog_reset_n       in   1             asynchronous active-low reset
//  cfg_en             in   1             shift one bit from ccff_head this cycle
//  cfg_commit         in   1             single-cycle request: copy shadow -> active
//  ccff_head          in   1             serial config in
//  ccff_tail          out  1             serial config out = shadow[CFG_BITS-1]
//  cfg_valid          out  1             active config loaded; muxed outputs enabled
//  cfg_err            out  1             sticky: commit with wrong bit count
//  chanx_right_in     in   CHAN_WIDTH    X channel, incoming from right
//  chany_bottom_in    in   CHAN_WIDTH    Y channel, incoming from bottom
//  right_top_inpad    in   1             right-top grid inpad pin
//  right_bottom_opin  in   NUM_OPINS     right-bottom grid O pins
//  bottom_left_inpad  in   1             bottom-left grid inpad pin
//  chanx_right_out    out  CHAN_WIDTH    X channel, outgoing to the right
//  chany_bottom_out   out  CHAN_WIDTH    Y channel, outgoing downward
// BEHAVIOUR
//  Reset (async): shadow=0, active=0, bit count=0, cfg_valid=0, cfg_err=0, ccff_tail=0.
//  Shift: when cfg_en=1 and cfg_commit=0: shadow <= {shadow[CFG_BITS-2:0], ccff_head}.
//    count saturates at CFG_BITS+1. ccff_tail updates on the same edge.
//  Commit (cfg_commit=1): commit wins over cfg_en in the same cycle, and no shift occurs.
//    count==CFG_BITS  -> next edge: active<=shadow, cfg_valid<=1, count<=0.
//    count!=CFG_BITS  -> cfg_err<=1, count<=0; active and cfg_valid are unchanged.
//  cfg_err clears only on reset. Shadow is retained after commit, so readback via ccff_tail stays possible.
//  FSM (cfg_valid, count): UNCONF -> LOADING (first shift) -> ACTIVE (good commit).
//    ACTIVE -> RELOAD on a shift; the old active config keeps routing until the next good commit.
//  Field map of active, LSB-first:
//    right wide mux 0..WIDE_MUXES-1 (SW bits each)
//    then right 2:1 muxes WIDE_MUXES..CHAN_WIDTH-2 (1 bit each)
//    then bottom muxes 0..BOTTOM_MUXES-1 (1 bit each).
//    The first bit shifted in lands at CFG_BITS-1.
//  Routing (combinational from active; every muxed output is 0 while cfg_valid=0):
//    right i < WIDE_MUXES: sel 0 = right_top_inpad; sel 1..NUM_OPINS = opin[sel-1];
//      sel NUM_OPINS+1 = chany_bottom_in[CHAN_WIDTH-2-i]; sel out of range -> 0.
//    right WIDE_MUXES <= i <= CHAN_WIDTH-2, with j = i-WIDE_MUXES:
//      sel 0 = (j==0 ? right_top_inpad : opin[(j-1)%NUM_OPINS]); sel 1 = chany_bottom_in[CHAN_WIDTH-2-i].
//    chanx_right_out[CHAN_WIDTH-1] = chany_bottom_in[CHAN_WIDTH-1]  (direct, always).
//    bottom b < BOTTOM_MUXES: sel 0 = chanx_right_in[CHAN_WIDTH-2-b]; sel 1 = bottom_left_inpad.
//    bottom BOTTOM_MUXES <= k <= CHAN_WIDTH-2: chany_bottom_out[k] = chanx_right_in[CHAN_WIDTH-2-k]  (direct).
//    chany_bottom_out[CHAN_WIDTH-1] = chanx_right_in[CHAN_WIDTH-1]  (direct).
//  Reset mid-load: everything clears; muxed outputs go to 0 immediately.
// STRUCTURE
//  Package sb_pkg: clog2 function, SW/CFG_BITS derivation functions, field-offset function, FSM state enum.
//  Sub-module sb_cfg_chain: shift register, shadow/active registers, counter, FSM, err/valid.
//  Top level: generate loops of muxes slicing active by field offsets.
// TESTING
//  1 Reset: hold prog_reset_n=0, drive inputs -> cfg_valid=0, cfg_err=0, chanx_right_out[0..10]=0,
//    chanx_right_out[11]=chany_bottom_in[11].
//  2 Defaults: shift 20 bits, commit -> cfg_valid=1; wide mux 0 sel=9 (1001b) routes chany_bottom_in[10] to out[0];
//    sel=12 gives 0.
//  3 Short load: shift 19 bits, commit -> cfg_err=1, cfg_valid stays 0, outputs stay 0.
//  4 Reload: active config A routing; shift 20 bits of config B without commit -> outputs still follow A;
//    commit -> outputs follow B.
//  5 Readback and same-cycle priority: load 20 bits, shift 20 more with ccff_head=0 -> ccff_tail replays the
//    original bits in order; cfg_en=1 together with cfg_commit=1 -> no shift, commit only.
//  6 Parameter sweep CHAN_WIDTH=8, NUM_OPINS=4, WIDE_MUXES=1, BOTTOM_MUXES=2 -> CFG_BITS=3+6+2=11;
//    an 11-bit load commits cleanly and a random routing check matches the reference model.

Source files
------------

// File: rtl/sb_param_shadow_cfg_pkg.sv
// Shared types and elaboration-time helpers for the shadow-configured switch block.
package sb_param_shadow_cfg_pkg;

  typedef enum logic [1:0] {
    StUnconf,
    StLoading,
    StActive,
    StReload
  } cfg_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned num_opins);
    return clog2(num_opins + 2);
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned chan_width,
                                           input int unsigned num_opins,
                                           input int unsigned wide_muxes,
                                           input int unsigned bottom_muxes);
    return wide_muxes * sel_width(num_opins) + (chan_width - 1 - wide_muxes) + bottom_muxes;
  endfunction

  // Bit offset of right-track mux i inside the active register (LSB-first field map).
  function automatic int unsigned right_offset(input int unsigned i, input int unsigned sw,
                                               input int unsigned wide_muxes);
    return (i < wide_muxes) ? i * sw : wide_muxes * sw + (i - wide_muxes);
  endfunction

  function automatic int unsigned bottom_offset(input int unsigned b,
                                                input int unsigned chan_width,
                                                input int unsigned sw,
                                                input int unsigned wide_muxes);
    return wide_muxes * sw + (chan_width - 1 - wide_muxes) + b;
  endfunction

endpackage

// File: rtl/sb_param_shadow_cfg_if.sv
// Configuration chain and routing signals of the switch block, grouped for port use.
interface sb_param_shadow_cfg_if #(
  parameter int unsigned CHAN_WIDTH = 12,
  parameter int unsigned NUM_OPINS  = 8
);
  logic                  cfg_en;
  logic                  cfg_commit;
  logic                  ccff_head;
  logic                  ccff_tail;
  logic                  cfg_valid;
  logic                  cfg_err;
  logic [CHAN_WIDTH-1:0] chanx_right_in;
  logic [CHAN_WIDTH-1:0] chany_bottom_in;
  logic                  right_top_inpad;
  logic [NUM_OPINS-1:0]  right_bottom_opin;
  logic                  bottom_left_inpad;
  logic [CHAN_WIDTH-1:0] chanx_right_out;
  logic [CHAN_WIDTH-1:0] chany_bottom_out;

  modport master (
    output cfg_en, cfg_commit, ccff_head, chanx_right_in, chany_bottom_in,
           right_top_inpad, right_bottom_opin, bottom_left_inpad,
    input  ccff_tail, cfg_valid, cfg_err, chanx_right_out, chany_bottom_out
  );

  modport slave (
    input  cfg_en, cfg_commit, ccff_head, chanx_right_in, chany_bottom_in,
           right_top_inpad, right_bottom_opin, bottom_left_inpad,
    output ccff_tail, cfg_valid, cfg_err, chanx_right_out, chany_bottom_out
  );
endinterface

// File: rtl/sb_param_shadow_cfg_chain.sv
// Serial config chain: shadow shift register, atomic commit to active, bit-count checking.
module sb_param_shadow_cfg_chain
  import sb_param_shadow_cfg_pkg::*;
#(
  parameter int unsigned CfgBits = 20
) (
  input  logic               prog_clk,
  input  logic               prog_reset_n,
  input  logic               cfg_en,
  input  logic               cfg_commit,
  input  logic               ccff_head,
  output logic               ccff_tail,
  output logic               cfg_valid,
  output logic               cfg_err,
  output logic [CfgBits-1:0] active
);

  localparam int unsigned CntW = clog2(CfgBits + 2);

  logic [CfgBits-1:0] shadow_q, active_q;
  logic [CntW-1:0]    count_q;
  logic               valid_q, err_q;
  cfg_state_e         state_q;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= StUnconf;
    end else if (cfg_commit) begin
      // Commit wins over a simultaneous shift request.
      count_q <= '0;
      if (count_q == CntW'(CfgBits)) begin
        active_q <= shadow_q;
        valid_q  <= 1'b1;
        state_q  <= StActive;
      end else begin
        err_q   <= 1'b1;
        state_q <= valid_q ? StActive : StUnconf;
      end
    end else if (cfg_en) begin
      shadow_q <= {shadow_q[CfgBits-2:0], ccff_head};
      if (count_q != CntW'(CfgBits + 1)) count_q <= count_q + 1'b1;
      unique case (state_q)
        StUnconf: state_q <= StLoading;
        StActive: state_q <= StReload;
        default:  state_q <= state_q;
      endcase
    end
  end

  assign ccff_tail = shadow_q[CfgBits-1];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;
  assign active    = active_q;

endmodule

// File: rtl/sb_param_shadow_cfg.sv
// Parametrised left-edge switch block whose routing muxes are driven from a committed config.
module sb_param_shadow_cfg
  import sb_param_shadow_cfg_pkg::*;
#(
  parameter int unsigned CHAN_WIDTH   = 12,
  parameter int unsigned NUM_OPINS    = 8,
  parameter int unsigned WIDE_MUXES   = 2,
  parameter int unsigned BOTTOM_MUXES = 3
) (
  input logic              prog_clk,
  input logic              prog_reset_n,
  sb_param_shadow_cfg_if.slave bus
);

  localparam int unsigned SW       = sel_width(NUM_OPINS);
  localparam int unsigned CFG_BITS = cfg_bits(CHAN_WIDTH, NUM_OPINS, WIDE_MUXES, BOTTOM_MUXES);

  logic [CFG_BITS-1:0]   active;
  logic                  cfg_valid;
  logic [CHAN_WIDTH-1:0] x_out, y_out;

  sb_param_shadow_cfg_chain #(
    .CfgBits(CFG_BITS)
  ) u_chain (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .cfg_en      (bus.cfg_en),
    .cfg_commit  (bus.cfg_commit),
    .ccff_head   (bus.ccff_head),
    .ccff_tail   (bus.ccff_tail),
    .cfg_valid   (cfg_valid),
    .cfg_err     (bus.cfg_err),
    .active      (active)
  );

  for (genvar i = 0; i < WIDE_MUXES; i++) begin : g_wide
    localparam int unsigned Off = right_offset(i, SW, WIDE_MUXES);
    logic [SW-1:0] sel;
    logic          val;
    assign sel = active[Off +: SW];
    always_comb begin
      val = 1'b0;
      if (sel == '0) val = bus.right_top_inpad;
      else if (sel == SW'(NUM_OPINS + 1)) val = bus.chany_bottom_in[CHAN_WIDTH-2-i];
      for (int unsigned p = 0; p < NUM_OPINS; p++) begin
        if (sel == SW'(p + 1)) val = bus.right_bottom_opin[p];
      end
    end
    assign x_out[i] = cfg_valid & val;
  end

  for (genvar i = WIDE_MUXES; i <= CHAN_WIDTH - 2; i++) begin : g_narrow
    localparam int unsigned Off = right_offset(i, SW, WIDE_MUXES);
    logic in0;
    if (i == WIDE_MUXES) begin : g_pad
      assign in0 = bus.right_top_inpad;
    end else begin : g_opin
      assign in0 = bus.right_bottom_opin[(i - WIDE_MUXES - 1) % NUM_OPINS];
    end
    assign x_out[i] = cfg_valid & (active[Off] ? bus.chany_bottom_in[CHAN_WIDTH-2-i] : in0);
  end

  assign x_out[CHAN_WIDTH-1] = bus.chany_bottom_in[CHAN_WIDTH-1];

  for (genvar b = 0; b < BOTTOM_MUXES; b++) begin : g_bottom
    localparam int unsigned Off = bottom_offset(b, CHAN_WIDTH, SW, WIDE_MUXES);
    assign y_out[b] = cfg_valid &
                      (active[Off] ? bus.bottom_left_inpad : bus.chanx_right_in[CHAN_WIDTH-2-b]);
  end

  for (genvar k = BOTTOM_MUXES; k <= CHAN_WIDTH - 2; k++) begin : g_bottom_direct
    assign y_out[k] = bus.chanx_right_in[CHAN_WIDTH-2-k];
  end

  assign y_out[CHAN_WIDTH-1] = bus.chanx_right_in[CHAN_WIDTH-1];

  assign bus.chanx_right_out  = x_out;
  assign bus.chany_bottom_out = y_out;
  assign bus.cfg_valid        = cfg_valid;

endmodule

// File: tb/tb_sb_param_shadow_cfg.sv
// Scoreboard bench for the shadow-configured switch block: default and reduced parameter sets.
module tb_sb_param_shadow_cfg;

  logic prog_clk = 1'b0;
  logic prog_reset_n;
  always #5 prog_clk = ~prog_clk;

  sb_param_shadow_cfg_if #(.CHAN_WIDTH(12), .NUM_OPINS(8)) bus_a ();
  sb_param_shadow_cfg_if #(.CHAN_WIDTH(8), .NUM_OPINS(4)) bus_b ();

  sb_param_shadow_cfg dut_a (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .bus         (bus_a)
  );

  sb_param_shadow_cfg #(
    .CHAN_WIDTH  (8),
    .NUM_OPINS   (4),
    .WIDE_MUXES  (1),
    .BOTTOM_MUXES(2)
  ) dut_b (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .bus         (bus_b)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  typedef struct {
    bit          dut_b;
    string       tag;
    logic [31:0] x;
    logic [31:0] y;
    logic        valid;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Reference state for the default instance.
  logic [19:0] m_shadow, m_active;
  int          m_count;
  logic        m_valid, m_err;
  // Reference state for the reduced instance.
  logic [10:0] b_active;
  logic        b_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_x(int cw, int no, int wm, int sw, logic valid,
                                          logic [31:0] act, logic [31:0] cbi, logic inpad,
                                          logic [31:0] opin);
    logic [31:0] r;
    int sel, j;
    logic v;
    r = '0;
    for (int i = 0; i <= cw - 2; i++) begin
      if (i < wm) begin
        sel = int'((act >> (i * sw)) & ((32'd1 << sw) - 32'd1));
        if (sel == 0) v = inpad;
        else if (sel <= no) v = opin[sel-1];
        else if (sel == no + 1) v = cbi[cw-2-i];
        else v = 1'b0;
      end else begin
        j = i - wm;
        if (act[wm*sw+j]) v = cbi[cw-2-i];
        else v = (j == 0) ? inpad : opin[(j-1)%no];
      end
      r[i] = valid & v;
    end
    r[cw-1] = cbi[cw-1];
    return r;
  endfunction

  function automatic logic [31:0] model_y(int cw, int wm, int sw, int bm, logic valid,
                                          logic [31:0] act, logic [31:0] cri, logic blpad);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < cw; k++) begin
      if (k < bm) r[k] = valid & (act[wm*sw+(cw-1-wm)+k] ? blpad : cri[cw-2-k]);
      else if (k <= cw - 2) r[k] = cri[cw-2-k];
      else r[k] = cri[cw-1];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_count = 0; m_valid = 1'b0; m_err = 1'b0;
    b_active = '0; b_valid = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic com, input logic b);
    if (com) begin
      if (m_count == 20) begin
        m_active = m_shadow;
        m_valid  = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_count = 0;
    end else if (en) begin
      m_shadow = {m_shadow[18:0], b};
      if (m_count < 21) m_count++;
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut_b) begin
        check({e.tag, "_x"}, 32'(bus_b.chanx_right_out), e.x);
        check({e.tag, "_y"}, 32'(bus_b.chany_bottom_out), e.y);
        check({e.tag, "_valid"}, 32'(bus_b.cfg_valid), 32'(e.valid));
        check({e.tag, "_err"}, 32'(bus_b.cfg_err), 32'(e.err));
      end else begin
        check({e.tag, "_x"}, 32'(bus_a.chanx_right_out), e.x);
        check({e.tag, "_y"}, 32'(bus_a.chany_bottom_out), e.y);
        check({e.tag, "_valid"}, 32'(bus_a.cfg_valid), 32'(e.valid));
        check({e.tag, "_err"}, 32'(bus_a.cfg_err), 32'(e.err));
      end
    end
  endtask

  task automatic route_a(input string tag);
    exp_t e;
    @(negedge prog_clk);
    bus_a.chanx_right_in    = 12'($urandom);
    bus_a.chany_bottom_in   = 12'($urandom);
    bus_a.right_top_inpad   = 1'($urandom);
    bus_a.right_bottom_opin = 8'($urandom);
    bus_a.bottom_left_inpad = 1'($urandom);
    e.dut_b = 1'b0;
    e.tag   = tag;
    e.x     = model_x(12, 8, 2, 4, m_valid, 32'(m_active), 32'(bus_a.chany_bottom_in),
                      bus_a.right_top_inpad, 32'(bus_a.right_bottom_opin));
    e.y     = model_y(12, 2, 4, 3, m_valid, 32'(m_active), 32'(bus_a.chanx_right_in),
                      bus_a.bottom_left_inpad);
    e.valid = m_valid;
    e.err   = m_err;
    sb_q.push_back(e);
    #2;
    drain();
  endtask

  task automatic route_b(input string tag);
    exp_t e;
    @(negedge prog_clk);
    bus_b.chanx_right_in    = 8'($urandom);
    bus_b.chany_bottom_in   = 8'($urandom);
    bus_b.right_top_inpad   = 1'($urandom);
    bus_b.right_bottom_opin = 4'($urandom);
    bus_b.bottom_left_inpad = 1'($urandom);
    e.dut_b = 1'b1;
    e.tag   = tag;
    e.x     = model_x(8, 4, 1, 3, b_valid, 32'(b_active), 32'(bus_b.chany_bottom_in),
                      bus_b.right_top_inpad, 32'(bus_b.right_bottom_opin));
    e.y     = model_y(8, 1, 3, 2, b_valid, 32'(b_active), 32'(bus_b.chanx_right_in),
                      bus_b.bottom_left_inpad);
    e.valid = b_valid;
    e.err   = 1'b0;
    sb_q.push_back(e);
    #2;
    drain();
  endtask

  task automatic shift_a(input logic b, input logic with_commit);
    bus_a.cfg_en     = 1'b1;
    bus_a.ccff_head  = b;
    bus_a.cfg_commit = with_commit;
    @(posedge prog_clk);
    model_edge(1'b1, with_commit, b);
    #1;
    bus_a.cfg_en     = 1'b0;
    bus_a.cfg_commit = 1'b0;
  endtask

  task automatic commit_a();
    bus_a.cfg_commit = 1'b1;
    @(posedge prog_clk);
    model_edge(1'b0, 1'b1, 1'b0);
    #1;
    bus_a.cfg_commit = 1'b0;
  endtask

  task automatic load_a(input logic [19:0] cfg, input int nbits);
    for (int k = 0; k < nbits; k++) shift_a(cfg[19-k], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge prog_clk);
    prog_reset_n = 1'b0;
    model_reset();
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
  endtask

  logic [19:0] cfg, cfg2;
  logic [10:0] cfg_b;

  initial begin
    prog_reset_n = 1'b0;
    model_reset();
    bus_a.cfg_en = 1'b0; bus_a.cfg_commit = 1'b0; bus_a.ccff_head = 1'b0;
    bus_b.cfg_en = 1'b0; bus_b.cfg_commit = 1'b0; bus_b.ccff_head = 1'b0;

    // Reset: muxed outputs held at 0, direct track passes through.
    route_a("rst");
    route_a("rst2");
    check("rst_tail", 32'(bus_a.ccff_tail), 32'd0);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;

    // Full load with wide mux 0 sel=9 -> chany_bottom_in[10].
    cfg = 20'($urandom);
    cfg[3:0] = 4'd9;
    load_a(cfg, 20);
    commit_a();
    check("load_valid", 32'(bus_a.cfg_valid), 32'd1);
    @(negedge prog_clk);
    bus_a.chany_bottom_in = 12'h400;
    bus_a.right_top_inpad = 1'b0;
    bus_a.right_bottom_opin = 8'h00;
    #1 check("sel9_hi", 32'(bus_a.chanx_right_out[0]), 32'd1);
    bus_a.chany_bottom_in = 12'hbff;
    bus_a.right_top_inpad = 1'b1;
    bus_a.right_bottom_opin = 8'hff;
    #1 check("sel9_lo", 32'(bus_a.chanx_right_out[0]), 32'd0);
    for (int n = 0; n < 3; n++) route_a("sel9");

    // Out-of-range select gives 0.
    cfg = 20'($urandom);
    cfg[3:0] = 4'd12;
    load_a(cfg, 20);
    commit_a();
    @(negedge prog_clk);
    bus_a.chany_bottom_in = 12'hfff;
    bus_a.right_top_inpad = 1'b1;
    bus_a.right_bottom_opin = 8'hff;
    #1 check("sel12", 32'(bus_a.chanx_right_out[0]), 32'd0);
    route_a("sel12");

    // Short load flags an error and leaves the block unconfigured.
    do_reset();
    load_a(20'($urandom), 19);
    commit_a();
    route_a("short");
    route_a("short2");

    // Reload: old config routes until the new one commits.
    do_reset();
    cfg  = 20'($urandom);
    cfg2 = ~cfg;
    load_a(cfg, 20);
    commit_a();
    route_a("cfgA");
    load_a(cfg2, 20);
    route_a("reload_A");
    route_a("reload_A2");
    commit_a();
    route_a("cfgB");
    route_a("cfgB2");

    // Readback through ccff_tail, then an over-length commit.
    do_reset();
    cfg = 20'($urandom);
    load_a(cfg, 20);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("tail%0d", k), 32'(bus_a.ccff_tail), 32'(cfg[19-k]));
      shift_a(1'b0, 1'b0);
    end
    commit_a();
    route_a("overlen");

    // Shift and commit together: commit only, shadow untouched.
    do_reset();
    cfg = 20'($urandom);
    load_a(cfg, 20);
    shift_a(~cfg[19], 1'b1);
    check("prio_tail", 32'(bus_a.ccff_tail), 32'(cfg[19]));
    route_a("prio");

    // Reset in the middle of a reload clears outputs without a clock edge.
    load_a(20'($urandom), 5);
    @(negedge prog_clk);
    bus_a.chany_bottom_in = 12'hfff;
    bus_a.right_top_inpad = 1'b1;
    bus_a.right_bottom_opin = 8'hff;
    bus_a.chanx_right_in = 12'hfff;
    #1;
    prog_reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_valid", 32'(bus_a.cfg_valid), 32'd0);
    check("midrst_x", 32'(bus_a.chanx_right_out), 32'h800);
    check("midrst_y", 32'(bus_a.chany_bottom_out), 32'hff8);
    @(negedge prog_clk);
    prog_reset_n = 1'b1;

    // Reduced parameter set: 11-bit config.
    route_b("b_unconf");
    cfg_b = 11'($urandom);
    for (int k = 0; k < 11; k++) begin
      bus_b.cfg_en = 1'b1;
      bus_b.ccff_head = cfg_b[10-k];
      @(posedge prog_clk);
      #1;
      bus_b.cfg_en = 1'b0;
    end
    bus_b.cfg_commit = 1'b1;
    @(posedge prog_clk);
    b_active = cfg_b;
    b_valid  = 1'b1;
    #1;
    bus_b.cfg_commit = 1'b0;
    for (int n = 0; n < 4; n++) route_b("b_cfg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
